controller_scratchpad_multi: RTL and testbench

Parametrised successor of the single-core scratchpad controller. Provides an OBI-slave register file that drives per-core clock-enable and reset for NUM_CORES cores. Adds hardware-timed reset pulses, a status register with a sticky W1C error bit, and a general-purpose scratch register. Sits between the host OBI bus and the GPGPU core clock/reset gating.

---
 rtl/controller_scratchpad_multi_if.sv | 33 +++
 rtl/controller_scratchpad_multi.sv | 160 ++++++++++++++++
 tb/tb_controller_scratchpad_multi.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/controller_scratchpad_multi_if.sv
// OBI request/response interfaces for the
// scratchpad controller register port.
interface obi_req_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt
  );

  modport master (
    output req, we, be, addr, wdata,
    input  gnt
  );
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output rvalid, rdata
  );

  modport slave (
    input rvalid, rdata
  );
endinterface

// File: rtl/controller_scratchpad_multi.sv
// Multi-core clock-enable / reset controller
// with OBI register port and timed reset pulses.
module controller_scratchpad_multi #(
  parameter int unsigned NUM_CORES        = 4,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  obi_req_if.slave             regs_req,
  obi_rsp_if.master            regs_rsp,
  output logic [NUM_CORES-1:0] clk_core_en_o,
  output logic [NUM_CORES-1:0] rst_n_core_o
);

  localparam int unsigned CW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned PW = 32 - NUM_CORES;

  typedef enum logic {IDLE, RESP} state_e;

  state_e state_q, state_d;

  logic                 we_q;
  logic [3:0]           be_q;
  logic [2:0]           idx_q;
  logic [31:0]          wdata_q;

  logic [NUM_CORES-1:0] clk_en_q;
  logic [NUM_CORES-1:0] rst_n_q;
  logic [NUM_CORES-1:0] pmask_q;
  logic [31:0]          scratch_q;
  logic [CW-1:0]        cnt_q;
  logic                 dropped_q;

  logic                 busy;
  logic [31:0]          bm;
  logic [NUM_CORES-1:0] m;
  logic                 wr;
  logic                 pulse_wr;
  logic                 pulse_go;
  logic                 pulse_drop;
  logic                 drop_clr;
  logic [31:0]          rd_val;
  logic                 unused_addr;

  assign unused_addr = ^{regs_req.addr[31:5], regs_req.addr[1:0]};

  assign busy = (cnt_q != '0);
  assign bm   = {{8{be_q[3]}}, {8{be_q[2]}},
                 {8{be_q[1]}}, {8{be_q[0]}}};
  assign m    = wdata_q[NUM_CORES-1:0] & bm[NUM_CORES-1:0];

  assign wr         = (state_q == RESP) & we_q;
  assign pulse_wr   = wr & (idx_q == 3'd2) & (m != '0);
  assign pulse_go   = pulse_wr & ~busy;
  assign pulse_drop = pulse_wr & busy;
  assign drop_clr   = wr & (idx_q == 3'd3)
                    & be_q[3] & wdata_q[31];

  // handshake state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // accept in IDLE, answer for one cycle in RESP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (regs_req.req) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs; rdata only carries reads
  always_comb begin
    regs_req.gnt    = 1'b0;
    regs_rsp.rvalid = 1'b0;
    regs_rsp.rdata  = '0;
    unique case (state_q)
      IDLE: regs_req.gnt = regs_req.req;
      RESP: begin
        regs_rsp.rvalid = 1'b1;
        if (!we_q) regs_rsp.rdata = rd_val;
      end
      default: ;
    endcase
  end

  // read mux, zero-extended core registers
  always_comb begin
    rd_val = '0;
    case (idx_q)
      3'd0:    rd_val = {{PW{1'b0}}, clk_en_q};
      3'd1:    rd_val = {{PW{1'b0}}, rst_n_q};
      3'd2:    rd_val = {{PW{1'b0}}, pmask_q};
      3'd3:    rd_val = {dropped_q, 30'd0, busy};
      3'd4:    rd_val = scratch_q;
      default: rd_val = '0;
    endcase
  end

  // capture the request at grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && regs_req.req) begin
      we_q    <= regs_req.we;
      be_q    <= regs_req.be;
      idx_q   <= regs_req.addr[4:2];
      wdata_q <= regs_req.wdata;
    end
  end

  // byte-lane-masked register writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_en_q  <= '0;
      rst_n_q   <= '0;
      scratch_q <= '0;
    end else if (wr) begin
      if (idx_q == 3'd0)
        clk_en_q <= (clk_en_q & ~bm[NUM_CORES-1:0])
                  | (wdata_q[NUM_CORES-1:0] & bm[NUM_CORES-1:0]);
      if (idx_q == 3'd1)
        rst_n_q <= (rst_n_q & ~bm[NUM_CORES-1:0])
                 | (wdata_q[NUM_CORES-1:0] & bm[NUM_CORES-1:0]);
      if (idx_q == 3'd4)
        scratch_q <= (scratch_q & ~bm) | (wdata_q & bm);
    end
  end

  // pulse counter and mask; mask clears as count hits 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      pmask_q <= '0;
    end else if (pulse_go) begin
      cnt_q   <= CW'(RST_PULSE_CYCLES);
      pmask_q <= m;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) pmask_q <= '0;
    end
  end

  // sticky drop flag; a new drop beats a W1C clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         dropped_q <= 1'b0;
    else if (pulse_drop) dropped_q <= 1'b1;
    else if (drop_clr)   dropped_q <= 1'b0;
  end

  assign rst_n_core_o  = rst_n_q  & ~({NUM_CORES{busy}} & pmask_q);
  assign clk_core_en_o = clk_en_q |  ({NUM_CORES{busy}} & pmask_q);

endmodule

// File: tb/tb_controller_scratchpad_multi.sv
// Directed testbench for the multi-core
// scratchpad controller.
module tb_controller_scratchpad_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] clk_en;
  logic [3:0] rst_nc;
  logic [31:0] rd;

  int n_chk;
  int n_fail;

  obi_req_if req_if ();
  obi_rsp_if rsp_if ();

  controller_scratchpad_multi #(
    .NUM_CORES       (4),
    .RST_PULSE_CYCLES(16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .regs_req     (req_if),
    .regs_rsp     (rsp_if),
    .clk_core_en_o(clk_en),
    .rst_n_core_o (rst_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [3:0] be,
                      output logic [31:0] rdata);
    @(posedge clk);
    #1;
    req_if.req   = 1'b1;
    req_if.we    = we;
    req_if.addr  = addr;
    req_if.wdata = wdata;
    req_if.be    = be;
    #1;
    chk("gnt", {31'd0, req_if.gnt}, 32'd1);
    @(posedge clk);
    #1;
    chk("rvalid", {31'd0, rsp_if.rvalid}, 32'd1);
    chk("gnt_resp", {31'd0, req_if.gnt}, 32'd0);
    rdata = rsp_if.rdata;
    req_if.req = 1'b0;
    if (we) chk("wr_rdata", rdata, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    logic [31:0] dummy;
    xfer(1'b1, a, d, be, dummy);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    xfer(1'b0, a, 32'd0, 4'hF, v);
    chk(tag, v, exp);
  endtask

  task automatic out_chk(input string tag,
                         input logic [3:0] en,
                         input logic [3:0] rn);
    chk({tag, "_en"}, {28'd0, clk_en}, {28'd0, en});
    chk({tag, "_rn"}, {28'd0, rst_nc}, {28'd0, rn});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    req_if.req   = 1'b0;
    req_if.we    = 1'b0;
    req_if.be    = 4'h0;
    req_if.addr  = '0;
    req_if.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    out_chk("rst", 4'h0, 4'h0);
    chk("rst_rvalid", {31'd0, rsp_if.rvalid}, 32'd0);
    chk("rst_rdata", rsp_if.rdata, 32'd0);
    chk("rst_gnt", {31'd0, req_if.gnt}, 32'd0);
    rd_chk("status0", 32'h0C, 32'h0);

    // handshake and scratch byte lanes
    rd_chk("scratch0", 32'h10, 32'h0);
    wr(32'h10, 32'hDEADBEEF, 4'b0101);
    rd_chk("scratch_be", 32'h10, 32'h00AD00EF);
    @(posedge clk);
    #1;
    chk("idle_rdata", rsp_if.rdata, 32'd0);

    // unmapped space
    wr(32'h18, 32'hFFFFFFFF, 4'hF);
    rd_chk("unmapped", 32'h18, 32'h0);

    // enables, visible the cycle after RESP
    wr(32'h00, 32'hF, 4'hF);
    out_chk("clken_resp", 4'h0, 4'h0);
    @(posedge clk);
    #1;
    out_chk("clken", 4'hF, 4'h0);
    wr(32'h04, 32'hF, 4'hF);
    @(posedge clk);
    #1;
    out_chk("rstn", 4'hF, 4'hF);
    wr(32'h04, 32'h5, 4'hF);
    @(posedge clk);
    #1;
    out_chk("rstn5", 4'hF, 4'h5);
    wr(32'h04, 32'h0, 4'b1110);
    rd_chk("rstn_be", 32'h04, 32'h5);
    rd_chk("addr_lo", 32'h07, 32'h5);

    // exact pulse
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h04, 32'hF, 4'hF);
    wr(32'h08, 32'h6, 4'hF);
    out_chk("pulse_pre", 4'h0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      out_chk("pulse_on", 4'h6, 4'h9);
    end
    @(posedge clk);
    #1;
    out_chk("pulse_off", 4'h0, 4'hF);
    rd_chk("status_idle", 32'h0C, 32'h0);
    rd_chk("pmask_idle", 32'h08, 32'h0);

    // masked-out pulse is a no-op
    wr(32'h08, 32'hF, 4'b1110);
    rd_chk("pulse_nomask", 32'h0C, 32'h0);

    // drop during active pulse
    wr(32'h08, 32'h6, 4'hF);
    rd_chk("status_busy", 32'h0C, 32'h1);
    wr(32'h08, 32'h1, 4'hF);
    @(posedge clk);
    #1;
    out_chk("drop_out", 4'h6, 4'h9);
    rd_chk("status_drop", 32'h0C, 32'h80000001);
    rd_chk("pmask_busy", 32'h08, 32'h6);
    repeat (20) @(posedge clk);
    #1;
    out_chk("drop_end", 4'h0, 4'hF);
    rd_chk("sticky", 32'h0C, 32'h80000000);
    wr(32'h0C, 32'h80000000, 4'h7);
    rd_chk("w1c_nolane", 32'h0C, 32'h80000000);
    wr(32'h0C, 32'h80000000, 4'hF);
    rd_chk("w1c", 32'h0C, 32'h0);

    // async reset mid-pulse
    wr(32'h08, 32'h6, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    out_chk("mid_pulse", 4'h6, 4'h9);
    rst_n = 1'b0;
    #1;
    out_chk("async_rst", 4'h0, 4'h0);
    chk("async_rvalid", {31'd0, rsp_if.rvalid}, 32'd0);
    #10;
    rst_n = 1'b1;
    rd_chk("rst_status", 32'h0C, 32'h0);
    rd_chk("rst_pmask", 32'h08, 32'h0);
    rd_chk("rst_scratch", 32'h10, 32'h0);
    out_chk("post_rst", 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
